// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder decoder: synchronise, debounce, decode detents, track signed position.
// Latency: 2 sync + DEBOUNCE_CYCLES debounce cycles to accept an input, then 1 cycle to ROT_EVENT.
// Backpressure: none; ROT_EVENT is a single-cycle pulse and the consumer must sample it when it fires.
module rotary_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rot_a,
    input  logic       i_rot_b,
    input  logic       i_err_clr,
    output logic       o_rot_event,
    output logic       o_rot_dir,
    output logic [7:0] o_pos,
    output logic       o_err
);

    // Last counter value before a changed input is accepted.
    localparam logic [15:0] LP_CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Decoder states; each non-WAIT state corresponds to one debounced {A,B} code.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,   // 00
        S_CW1  = 3'd1,   // 10
        S_CW2  = 3'd2,   // 11
        S_CW3  = 3'd3,   // 01
        S_CCW1 = 3'd4,   // 01
        S_CCW2 = 3'd5,   // 11
        S_CCW3 = 3'd6,   // 10
        S_WAIT = 3'd7    // after an illegal jump, parked until 00
    } state_t;

    // Bit 1 carries phase A, bit 0 carries phase B throughout.
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0][15:0] r_cnt;

    state_t           r_state;
    logic             r_event;
    logic             r_dir;
    logic [7:0]       r_pos;
    logic             r_err;

    state_t           w_state_nxt;
    logic             w_illegal;
    logic             w_evt_cw;
    logic             w_evt_ccw;

    // Two-flop synchroniser for the asynchronous encoder phases.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {i_rot_a, i_rot_b};
            r_sync2 <= r_sync1;
        end
    end

    // Per-phase debounce: a change is accepted only after it persists without interruption.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deb <= 2'b00;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    // Input agrees with accepted value (or bounced back): restart the count.
                    r_cnt[i] <= 16'd0;
                end else if (r_cnt[i] == LP_CNT_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= 16'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Next-state decode: forward steps advance, single-bit reversals step back,
    // two-bit jumps are illegal and park in WAIT unless they land on 00.
    always_comb begin
        w_state_nxt = r_state;
        w_illegal   = 1'b0;
        w_evt_cw    = 1'b0;
        w_evt_ccw   = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (r_deb)
                    2'b10:   w_state_nxt = S_CW1;
                    2'b01:   w_state_nxt = S_CCW1;
                    2'b11: begin
                        w_state_nxt = S_WAIT;
                        w_illegal   = 1'b1;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
            S_CW1: begin
                case (r_deb)
                    2'b11:   w_state_nxt = S_CW2;
                    2'b00:   w_state_nxt = S_IDLE;
                    2'b01: begin
                        w_state_nxt = S_WAIT;
                        w_illegal   = 1'b1;
                    end
                    default: w_state_nxt = S_CW1;
                endcase
            end
            S_CW2: begin
                case (r_deb)
                    2'b01:   w_state_nxt = S_CW3;
                    2'b10:   w_state_nxt = S_CW1;
                    2'b00: begin
                        w_state_nxt = S_IDLE;
                        w_illegal   = 1'b1;
                    end
                    default: w_state_nxt = S_CW2;
                endcase
            end
            S_CW3: begin
                case (r_deb)
                    2'b00: begin
                        w_state_nxt = S_IDLE;
                        w_evt_cw    = 1'b1;
                    end
                    2'b11:   w_state_nxt = S_CW2;
                    2'b10: begin
                        w_state_nxt = S_WAIT;
                        w_illegal   = 1'b1;
                    end
                    default: w_state_nxt = S_CW3;
                endcase
            end
            S_CCW1: begin
                case (r_deb)
                    2'b11:   w_state_nxt = S_CCW2;
                    2'b00:   w_state_nxt = S_IDLE;
                    2'b10: begin
                        w_state_nxt = S_WAIT;
                        w_illegal   = 1'b1;
                    end
                    default: w_state_nxt = S_CCW1;
                endcase
            end
            S_CCW2: begin
                case (r_deb)
                    2'b10:   w_state_nxt = S_CCW3;
                    2'b01:   w_state_nxt = S_CCW1;
                    2'b00: begin
                        w_state_nxt = S_IDLE;
                        w_illegal   = 1'b1;
                    end
                    default: w_state_nxt = S_CCW2;
                endcase
            end
            S_CCW3: begin
                case (r_deb)
                    2'b00: begin
                        w_state_nxt = S_IDLE;
                        w_evt_ccw   = 1'b1;
                    end
                    2'b11:   w_state_nxt = S_CCW2;
                    2'b01: begin
                        w_state_nxt = S_WAIT;
                        w_illegal   = 1'b1;
                    end
                    default: w_state_nxt = S_CCW3;
                endcase
            end
            S_WAIT: begin
                if (r_deb == 2'b00) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state and registered outputs; event, direction and position move together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_event <= 1'b0;
            r_dir   <= 1'b0;
            r_pos   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_event <= w_evt_cw | w_evt_ccw;
            if (w_evt_cw) begin
                r_dir <= 1'b1;
                r_pos <= r_pos + 8'd1;
            end else if (w_evt_ccw) begin
                r_dir <= 1'b0;
                r_pos <= r_pos - 8'd1;
            end
            // A new illegal jump takes priority over a clear in the same cycle.
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_rot_event = r_event;
    assign o_rot_dir   = r_dir;
    assign o_pos       = r_pos;
    assign o_err       = r_err;

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with DEBOUNCE_CYCLES=4.
// Checks reset, CW/CCW detents, event latency, glitch rejection, partial turns, errors, wrap, mid-turn reset.
// Inputs are driven 1 time unit after the rising edge and outputs sampled there too.
module tb_rotary_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rot_a;
    logic       rot_b;
    logic       err_clr;
    logic       rot_event;
    logic       rot_dir;
    logic [7:0] pos;
    logic       err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int ev_cnt = 0;
    int e0     = 0;

    rotary_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rot_a     (rot_a),
        .i_rot_b     (rot_b),
        .i_err_clr   (err_clr),
        .o_rot_event (rot_event),
        .o_rot_dir   (rot_dir),
        .o_pos       (pos),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Count every cycle in which the event pulse is high.
    always @(negedge clk) begin
        if (rot_event) ev_cnt++;
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: observed simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ab, input int n);
        {rot_a, rot_b} = ab;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cw_detent(input int n);
        drive(2'b10, n);
        drive(2'b11, n);
        drive(2'b01, n);
        drive(2'b00, n);
    endtask

    task automatic ccw_detent(input int n);
        drive(2'b01, n);
        drive(2'b11, n);
        drive(2'b10, n);
        drive(2'b00, n);
    endtask

    initial begin
        rst_n   = 1'b0;
        rot_a   = 1'b0;
        rot_b   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_event", 16'(rot_event), 16'h0);
        chk("reset_dir",   16'(rot_dir),   16'h0);
        chk("reset_pos",   16'(pos),       16'h0);
        chk("reset_err",   16'(err),       16'h0);
        rst_n = 1'b1;
        drive(2'b00, 5);

        // Clean CW detent with exact event latency on the final 00.
        e0 = ev_cnt;
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        {rot_a, rot_b} = 2'b00;
        repeat (6) @(posedge clk);
        #1;
        chk("cw_lat_before", 16'(rot_event), 16'h0);
        @(posedge clk);
        #1;
        chk("cw_lat_event", 16'(rot_event), 16'h1);
        chk("cw_lat_pos",   16'(pos),       16'h01);
        chk("cw_lat_dir",   16'(rot_dir),   16'h1);
        @(posedge clk);
        #1;
        chk("cw_pulse_end", 16'(rot_event), 16'h0);
        drive(2'b00, 8);
        chk("cw_count", 16'(ev_cnt - e0), 16'd1);
        chk("cw_pos",   16'(pos),         16'h01);
        chk("cw_err",   16'(err),         16'h0);

        // Clean CCW detent from zero.
        do_reset();
        drive(2'b00, 5);
        e0 = ev_cnt;
        ccw_detent(10);
        chk("ccw_count", 16'(ev_cnt - e0), 16'd1);
        chk("ccw_pos",   16'(pos),         16'hFF);
        chk("ccw_dir",   16'(rot_dir),     16'h0);
        chk("ccw_err",   16'(err),         16'h0);

        // CW detent with a short glitch ahead of every edge.
        do_reset();
        drive(2'b00, 5);
        e0 = ev_cnt;
        drive(2'b10, 2); drive(2'b00, 1); drive(2'b10, 10);
        drive(2'b11, 2); drive(2'b10, 1); drive(2'b11, 10);
        drive(2'b01, 2); drive(2'b11, 1); drive(2'b01, 10);
        drive(2'b00, 2); drive(2'b01, 1); drive(2'b00, 10);
        chk("glitch_count", 16'(ev_cnt - e0), 16'd1);
        chk("glitch_pos",   16'(pos),         16'h01);
        chk("glitch_dir",   16'(rot_dir),     16'h1);
        chk("glitch_err",   16'(err),         16'h0);

        // Partial turn reversed back to rest.
        e0 = ev_cnt;
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 10);
        chk("partial_count", 16'(ev_cnt - e0), 16'd0);
        chk("partial_pos",   16'(pos),         16'h01);
        chk("partial_err",   16'(err),         16'h0);

        // Illegal jump 00 -> 11, then back to 00.
        e0 = ev_cnt;
        drive(2'b11, 10);
        chk("jump_err_set", 16'(err), 16'h1);
        drive(2'b00, 10);
        chk("jump_count", 16'(ev_cnt - e0), 16'd0);
        chk("jump_pos",   16'(pos),         16'h01);
        chk("jump_err_held", 16'(err),      16'h1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("errclr_clears", 16'(err), 16'h0);

        // Re-arm ERR, then clear in the very cycle a new illegal jump lands.
        drive(2'b11, 10);
        chk("rearm_err", 16'(err), 16'h1);
        drive(2'b00, 10);
        {rot_a, rot_b} = 2'b11;
        repeat (6) @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_set_wins", 16'(err), 16'h1);
        drive(2'b11, 5);
        drive(2'b00, 10);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("errclr_after_wait", 16'(err), 16'h0);
        chk("err_seq_count", 16'(ev_cnt - e0), 16'd0);
        chk("err_seq_pos",   16'(pos),         16'h01);

        // Position wraps after 128 CW detents, then back through one CCW.
        do_reset();
        drive(2'b00, 5);
        e0 = ev_cnt;
        for (int i = 0; i < 128; i++) cw_detent(8);
        chk("wrap_count", 16'(ev_cnt - e0), 16'd128);
        chk("wrap_pos",   16'(pos),         16'h80);
        chk("wrap_dir",   16'(rot_dir),     16'h1);
        ccw_detent(8);
        chk("unwrap_pos", 16'(pos),     16'h7F);
        chk("unwrap_dir", 16'(rot_dir), 16'h0);
        cw_detent(8);
        chk("rewrap_pos", 16'(pos), 16'h80);

        // Reset while sitting in CW2 abandons the detent.
        drive(2'b10, 10);
        drive(2'b11, 10);
        rst_n = 1'b0;
        #1;
        chk("midrst_event", 16'(rot_event), 16'h0);
        chk("midrst_dir",   16'(rot_dir),   16'h0);
        chk("midrst_pos",   16'(pos),       16'h00);
        chk("midrst_err",   16'(err),       16'h0);
        {rot_a, rot_b} = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        e0 = ev_cnt;
        drive(2'b01, 10);
        drive(2'b00, 10);
        chk("postrst_count", 16'(ev_cnt - e0), 16'd0);
        chk("postrst_pos",   16'(pos),         16'h00);
        chk("postrst_err",   16'(err),         16'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a synchronised input is accepted; legal range 1..65535.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 ROT_A  input  1  raw encoder phase A, asynchronous to CLK, bouncy.
REQ-005 ROT_B  input  1  raw encoder phase B, asynchronous to CLK, bouncy.
REQ-006 ERR_CLR  input  1  synchronous clear of ERR, active high.
REQ-007 ROT_EVENT  output  1  one-cycle pulse per completed detent.
REQ-008 ROT_DIR  output  1  direction of the last event: 1 = CW, 0 = CCW; valid when ROT_EVENT=1 and held afterwards.
REQ-009 POS  output  8  signed detent count, two's complement.
REQ-010 ERR  output  1  sticky flag: illegal quadrature transition seen.

Function
REQ-011 ROT_A and ROT_B SHALL each pass through a 2-flop synchroniser before any other logic.
REQ-012 Each synchronised phase SHALL have its own 16-bit debounce counter: counter clears when synced value equals debounced value; otherwise it increments, and when it reaches DEBOUNCE_CYCLES-1 the debounced value takes the synced value and the counter clears.
REQ-013 Any return of the synced input to the debounced value before acceptance SHALL clear that counter without changing the debounced value.
REQ-014 Decoder FSM SHALL run on debounced {A,B}; states IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3; rest position {A,B}=00.
REQ-015 CW sequence: IDLE(00) -> CW1(10) -> CW2(11) -> CW3(01) -> IDLE(00); CCW sequence: IDLE(00) -> CCW1(01) -> CCW2(11) -> CCW3(10) -> IDLE(00).
REQ-016 Unchanged {A,B} SHALL hold the current state.
REQ-017 A single-bit change back to the previous state's code SHALL step back one state (partial turn reversal); reaching 00 this way SHALL go to IDLE with no event.
REQ-018 A change of both bits in one debounced cycle SHALL force IDLE if the new code is 00, otherwise a WAIT state, set ERR, and emit no event; WAIT SHALL go to IDLE when {A,B}=00.
REQ-019 Transition CW3->IDLE SHALL assert ROT_EVENT for exactly one cycle with ROT_DIR=1 and POS+1; CCW3->IDLE SHALL do the same with ROT_DIR=0 and POS-1.
REQ-020 ROT_EVENT, ROT_DIR and POS SHALL be registered and update in the same cycle; latency from the debounced 00 arriving to ROT_EVENT high SHALL be 1 cycle.
REQ-021 POS SHALL wrap: 127+1 -> -128, -128-1 -> 127; no saturation.
REQ-022 ERR_CLR SHALL clear ERR the next cycle; if an illegal transition occurs in the same cycle, ERR SHALL remain 1 (set wins).
REQ-023 In WAIT no event, no POS change; leaving WAIT requires debounced 00.

Reset
REQ-024 While RST_N=0: synchronisers and debounced values = 0, debounce counters = 0, FSM = IDLE, ROT_EVENT=0, ROT_DIR=0, POS=0, ERR=0.
REQ-025 Reset asserted mid-sequence SHALL abandon the partial detent with no event; after release the FSM SHALL start from IDLE against debounced value 00, so inputs held non-zero at release are processed as a fresh move from 00.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean CW cycle 00,10,11,01,00 each held 10 cycles -> exactly one ROT_EVENT pulse, ROT_DIR=1, POS=1, ERR=0.
REQ-027 Clean CCW cycle 00,01,11,10,00 from POS=0 -> one pulse, ROT_DIR=0, POS=-1 (8'hFF).
REQ-028 Each edge preceded by 3-cycle glitches (toggle, return within 2 cycles) -> debounced values unchanged by glitches; result identical to REQ-026.
REQ-029 Partial turn 00,10,11,10,00 -> no ROT_EVENT, POS unchanged, ERR=0.
REQ-030 Jump 00 -> 11 in one step, then 00 -> ERR=1, no event, POS unchanged; ERR_CLR pulse -> ERR=0 next cycle; simultaneous ERR_CLR and a new illegal jump -> ERR stays 1.
REQ-031 128 CW detents from POS=0 -> POS=8'h80 (-128); one CCW detent -> POS=8'h7F; RST_N pulsed low while in CW2 -> all outputs 0 immediately, no event after release.
